// File: rtl/z80_mem_arbiter_if.sv
// z80_mem_arbiter_if
//  Bundles the three buses around the shared 64 KB BSRAM:
//   z_*    Z80 side: synchronised request level, latched address/data, read data, WAIT_n
//   d_*    DMA/loader side: level request held until d_gnt, grant pulse, read data/valid
//   mem_*  registered strobes into the single-port memory array and its read data
//  Modports:
//   slave  - the arbiter (consumes requests and mem_rdata, drives everything else)
//   master - the surrounding environment (Z80 bus, DMA engine and memory array)
interface z80_mem_arbiter_if;
    logic        z_req;
    logic        z_we;
    logic [15:0] z_addr;
    logic [7:0]  z_wdata;
    logic [7:0]  z_rdata;
    logic        z_wait_n;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_gnt;
    logic [7:0]  d_rdata;
    logic        d_rvalid;

    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  z_req, z_we, z_addr, z_wdata,
        output z_rdata, z_wait_n,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rdata, d_rvalid,
        output mem_ce, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output z_req, z_we, z_addr, z_wdata,
        input  z_rdata, z_wait_n,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rdata, d_rvalid,
        input  mem_ce, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/z80_mem_arbiter.sv
// z80_mem_arbiter
//  Shares the single-port 64 KB BSRAM between the Z80 bus and a DMA/loader port.
//  The Z80 has priority; a DMA request waiting DMA_STARVE cycles is forced ahead of
//  a pending Z80 access. Z80 writes below ROM_LIMIT are silently dropped (the issue
//  slot is still spent so bus timing does not depend on the address).
//  Ports:
//   clk      system clock, single domain
//   reset_n  asynchronous active-low reset; aborts any access in flight
//   bus      z80_mem_arbiter_if.slave: Z80 port (z_*), DMA port (d_*), memory port (mem_*)
module z80_mem_arbiter #(
    parameter logic [15:0] ROM_LIMIT  = 16'h8000,
    parameter int          DMA_STARVE = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_mem_arbiter_if.slave   bus
);
    localparam int                CNT_W      = $clog2(DMA_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DMA_STARVE);

    typedef enum logic [1:0] {IDLE, ISSUE_Z, ISSUE_D, RDATA} state_t;

    state_t            state, state_nx;
    logic              z_req_d;
    logic              z_pend;
    logic              z_we_q;
    logic [15:0]       z_addr_q;
    logic [7:0]        z_wdata_q;
    logic              rd_is_d;
    logic [CNT_W-1:0]  starve_cnt;
    logic [7:0]        d_rdata_q;

    logic              z_edge;
    logic              starved;
    logic              pick_z;
    logic              pick_d;
    logic              ce_nx;
    logic              we_nx;
    logic [15:0]       addr_nx;
    logic [7:0]        wdata_nx;

    assign z_edge  = bus.z_req & ~z_req_d;
    assign starved = (starve_cnt >= STARVE_MAX);

    // Arbitration: a Z80 edge seen in IDLE holds the slot for one cycle while its
    // address is latched, so Z wins a same-cycle collision with d_req unless DMA
    // is already starved.
    always_comb begin
        pick_z = 1'b0;
        pick_d = 1'b0;
        if (state == IDLE) begin
            if (z_pend && !starved) begin
                pick_z = 1'b1;
            end else if (!(z_edge && !starved)) begin
                if (bus.d_req)
                    pick_d = 1'b1;
                else if (z_pend)
                    pick_z = 1'b1;
            end
        end
    end

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ---- next-state logic ----
    // mem_we still holds the issued operation's direction during ISSUE_*.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_z)
                    state_nx = ISSUE_Z;
                else if (pick_d)
                    state_nx = ISSUE_D;
            end
            ISSUE_Z,
            ISSUE_D: state_nx = bus.mem_we ? IDLE : RDATA;
            RDATA:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        ce_nx    = pick_d | (pick_z & ~(z_we_q & (z_addr_q < ROM_LIMIT)));
        we_nx    = 1'b0;
        addr_nx  = bus.mem_addr;
        wdata_nx = bus.mem_wdata;
        if (pick_d) begin
            we_nx    = bus.d_we;
            addr_nx  = bus.d_addr;
            wdata_nx = bus.d_wdata;
        end else if (pick_z) begin
            we_nx    = z_we_q;
            addr_nx  = z_addr_q;
            wdata_nx = z_wdata_q;
        end

        // WAIT_n drops only when a pending Z80 access is actually held off by DMA.
        bus.z_wait_n = ~(z_pend & (pick_d | (state == ISSUE_D) |
                                   ((state == RDATA) & rd_is_d)));
        bus.d_rvalid = (state == RDATA) & rd_is_d;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;
    end

    // ---- registered request capture, memory strobes and read data ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_req_d       <= 1'b0;
            z_pend        <= 1'b0;
            z_we_q        <= 1'b0;
            z_addr_q      <= '0;
            z_wdata_q     <= '0;
            rd_is_d       <= 1'b0;
            starve_cnt    <= '0;
            d_rdata_q     <= '0;
            bus.z_rdata   <= '0;
            bus.d_gnt     <= 1'b0;
            bus.mem_ce    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            z_req_d <= bus.z_req;

            // A new edge wins over consumption so a back-to-back request is not lost.
            if (z_edge) begin
                z_pend    <= 1'b1;
                z_we_q    <= bus.z_we;
                z_addr_q  <= bus.z_addr;
                z_wdata_q <= bus.z_wdata;
            end else if (pick_z) begin
                z_pend <= 1'b0;
            end

            if (!bus.d_req || bus.d_gnt)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + 1'b1;

            if (pick_d)
                rd_is_d <= 1'b1;
            else if (pick_z)
                rd_is_d <= 1'b0;

            bus.d_gnt     <= pick_d;
            bus.mem_ce    <= ce_nx;
            bus.mem_we    <= we_nx;
            bus.mem_addr  <= addr_nx;
            bus.mem_wdata <= wdata_nx;

            if (state == RDATA) begin
                if (rd_is_d)
                    d_rdata_q <= bus.mem_rdata;
                else
                    bus.z_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule
